// File: rtl/agc_ctrl_pkg.sv
// agc_ctrl_pkg: shared opcode, ALU, mux-select, state and control-word encodings for the agc sequencer
package agc_ctrl_pkg;
    localparam logic [2:0] OP_TC = 3'd0, OP_CCS = 3'd1, OP_DAS = 3'd2, OP_CA = 3'd3;
    localparam logic [2:0] OP_CS = 3'd4, OP_TS = 3'd5, OP_AD = 3'd6, OP_MASK = 3'd7;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4, ALU_NAND = 3'd5, ALU_NOR = 3'd6, ALU_OR = 3'd7;
    localparam logic [1:0] MADDR_Z = 2'd0, MADDR_S = 2'd1, MADDR_A = 2'd2;
    localparam logic [1:0] AMUX_MEM = 2'd0, AMUX_U = 2'd1, AMUX_NOTA = 2'd2, AMUX_G = 2'd3;
    localparam logic [1:0] XMUX_MEM = 2'd0, XMUX_Z = 2'd1, XMUX_S = 2'd2, XMUX_A = 2'd3;
    localparam logic [1:0] YMUX_MEM = 2'd0, YMUX_A = 2'd1, YMUX_ONE = 2'd2, YMUX_IMM = 2'd3;
    localparam logic [1:0] ZMUX_MEM = 2'd0, ZMUX_U = 2'd1, ZMUX_B = 2'd2;
    localparam logic [1:0] QMUX_MEM = 2'd0, QMUX_U = 2'd1, QMUX_Z = 2'd2;
    localparam logic BMUX_MEM = 1'b0, BMUX_U = 1'b1;
    localparam logic LPMUX_MEM = 1'b0, LPMUX_U = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_INCPC  = 3'd3,
        S_EXEC0  = 3'd4,
        S_EXEC1  = 3'd5,
        S_EXEC2  = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] aluOp;
        logic [1:0] maddrMux;
        logic [1:0] qMux;
        logic [1:0] aMux;
        logic [1:0] xMux;
        logic [1:0] zMux;
        logic [1:0] yMux;
        logic       lpMux;
        logic       bMux;
        logic       lpWe;
        logic       gWe;
        logic       qWe;
        logic       bWe;
        logic       aWe;
        logic       yWe;
        logic       xWe;
        logic       zWe;
        logic       memWe;
    } ctrl_t;
endpackage

// File: rtl/agc_ctrl_decode.sv
// agc_ctrl_decode: maps (micro-step, opcode) to the datapath control word and a last-step flag
module agc_ctrl_decode
    import agc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    output ctrl_t      ctrl,
    output logic       last
);
    // Default word is all-zero (ADD, every select 0, no writes); each step overrides only what it uses
    always_comb begin
        ctrl = '0;
        ctrl.aluOp = ALU_ADD;
        last = 1'b0;
        case (state)
            S_FETCH0: ctrl.maddrMux = MADDR_Z;
            S_FETCH1: begin
                ctrl.gWe = 1'b1;
                ctrl.bWe = 1'b1;
                ctrl.bMux = BMUX_MEM;
                ctrl.xWe = 1'b1;
                ctrl.xMux = XMUX_Z;
                ctrl.yWe = 1'b1;
                ctrl.yMux = YMUX_ONE;
            end
            S_INCPC: begin
                ctrl.zWe = 1'b1;
                ctrl.zMux = ZMUX_U;
            end
            S_EXEC0: begin
                case (opcode)
                    OP_TC: begin
                        ctrl.qWe = 1'b1;
                        ctrl.qMux = QMUX_Z;
                        ctrl.zWe = 1'b1;
                        ctrl.zMux = ZMUX_B;
                        last = 1'b1;
                    end
                    OP_CA, OP_CS, OP_AD, OP_MASK: ctrl.maddrMux = MADDR_S;
                    OP_TS: begin
                        ctrl.maddrMux = MADDR_S;
                        ctrl.memWe = 1'b1;
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_EXEC1: begin
                case (opcode)
                    OP_CA, OP_CS: begin
                        ctrl.aWe = 1'b1;
                        ctrl.aMux = AMUX_MEM;
                        last = opcode == OP_CA;
                    end
                    OP_AD, OP_MASK: begin
                        ctrl.xWe = 1'b1;
                        ctrl.xMux = XMUX_A;
                        ctrl.yWe = 1'b1;
                        ctrl.yMux = YMUX_MEM;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_EXEC2: begin
                ctrl.aWe = 1'b1;
                ctrl.aMux = opcode == OP_CS ? AMUX_NOTA : AMUX_U;
                ctrl.aluOp = opcode == OP_MASK ? ALU_AND : ALU_ADD;
                last = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/agc_sequencer.sv
// agc_sequencer: fetch / PC-increment / execute micro-sequencer driving the agc datapath controls
module agc_sequencer
    import agc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    output logic [2:0] alu_op,
    output logic [1:0] MAddr_MUX,
    output logic [1:0] Q_MUX,
    output logic [1:0] A_MUX,
    output logic [1:0] X_MUX,
    output logic [1:0] Z_MUX,
    output logic [1:0] Y_MUX,
    output logic       LP_MUX,
    output logic       B_MUX,
    output logic       LP_WE,
    output logic       G_WE,
    output logic       Q_WE,
    output logic       B_WE,
    output logic       A_WE,
    output logic       Y_WE,
    output logic       X_WE,
    output logic       Z_WE,
    output logic       mem_WE,
    output logic       busy,
    output logic       instr_done
);
    state_t     state, stateNext, wrapTo;
    logic [2:0] opLatch, opNext;
    ctrl_t      ctrlNext, ctrlQ;
    logic       lastNext;

    assign opNext = state == S_INCPC ? opcode : opLatch;
    assign wrapTo = run ? S_FETCH0 : S_IDLE;

    // instr_done already holds the last-step flag of the current state, so it decides the wrap
    always_comb begin
        stateNext = S_IDLE;
        case (state)
            S_IDLE:   stateNext = wrapTo;
            S_FETCH0: stateNext = S_FETCH1;
            S_FETCH1: stateNext = S_INCPC;
            S_INCPC:  stateNext = S_EXEC0;
            S_EXEC0:  stateNext = instr_done ? wrapTo : S_EXEC1;
            S_EXEC1:  stateNext = instr_done ? wrapTo : S_EXEC2;
            S_EXEC2:  stateNext = wrapTo;
            default:  stateNext = S_IDLE;
        endcase
    end

    agc_ctrl_decode u_decode (
        .state  (stateNext),
        .opcode (opNext),
        .ctrl   (ctrlNext),
        .last   (lastNext)
    );

    // Control word is decoded from the next state so registered outputs line up with the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            opLatch <= '0;
            ctrlQ <= '0;
            instr_done <= 1'b0;
        end else begin
            state <= stateNext;
            opLatch <= opNext;
            ctrlQ <= ctrlNext;
            instr_done <= lastNext;
        end
    end

    assign busy = state != S_IDLE;
    assign alu_op = ctrlQ.aluOp;
    assign MAddr_MUX = ctrlQ.maddrMux;
    assign Q_MUX = ctrlQ.qMux;
    assign A_MUX = ctrlQ.aMux;
    assign X_MUX = ctrlQ.xMux;
    assign Z_MUX = ctrlQ.zMux;
    assign Y_MUX = ctrlQ.yMux;
    assign LP_MUX = ctrlQ.lpMux;
    assign B_MUX = ctrlQ.bMux;
    assign LP_WE = ctrlQ.lpWe;
    assign G_WE = ctrlQ.gWe;
    assign Q_WE = ctrlQ.qWe;
    assign B_WE = ctrlQ.bWe;
    assign A_WE = ctrlQ.aWe;
    assign Y_WE = ctrlQ.yWe;
    assign X_WE = ctrlQ.xWe;
    assign Z_WE = ctrlQ.zWe;
    assign mem_WE = ctrlQ.memWe;
endmodule

// File: tb/tb_agc_sequencer.sv
// tb_agc_sequencer: directed-vector self-checking bench for agc_sequencer
module tb_agc_sequencer;
    logic       clk, rst, run;
    logic [2:0] opcode, alu_op;
    logic [1:0] MAddr_MUX, Q_MUX, A_MUX, X_MUX, Z_MUX, Y_MUX;
    logic       LP_MUX, B_MUX, LP_WE, G_WE, Q_WE, B_WE, A_WE, Y_WE, X_WE, Z_WE, mem_WE, busy, instr_done;
    logic [8:0] weVec;
    logic [27:0] allOut;
    int nChecks = 0, nFails = 0;

    // WE order: LP G Q B A Y X Z mem
    localparam logic [8:0] WE_NONE = 9'b000000000;
    localparam logic [8:0] WE_FETCH = 9'b010101100;
    localparam logic [8:0] WE_Z = 9'b000000010;
    localparam logic [8:0] WE_QZ = 9'b001000010;
    localparam logic [8:0] WE_A = 9'b000010000;
    localparam logic [8:0] WE_MEM = 9'b000000001;
    localparam logic [8:0] WE_YX = 9'b000001100;

    agc_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_op(alu_op),
        .MAddr_MUX(MAddr_MUX), .Q_MUX(Q_MUX), .A_MUX(A_MUX), .X_MUX(X_MUX), .Z_MUX(Z_MUX), .Y_MUX(Y_MUX),
        .LP_MUX(LP_MUX), .B_MUX(B_MUX), .LP_WE(LP_WE), .G_WE(G_WE), .Q_WE(Q_WE), .B_WE(B_WE),
        .A_WE(A_WE), .Y_WE(Y_WE), .X_WE(X_WE), .Z_WE(Z_WE), .mem_WE(mem_WE),
        .busy(busy), .instr_done(instr_done)
    );

    assign weVec = {LP_WE, G_WE, Q_WE, B_WE, A_WE, Y_WE, X_WE, Z_WE, mem_WE};
    assign allOut = {alu_op, MAddr_MUX, Q_MUX, A_MUX, X_MUX, Z_MUX, Y_MUX, LP_MUX, B_MUX, weVec, busy, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [8:0] we, input logic [1:0] maddr, input logic done);
        step();
        check({tag, ".we"}, 32'(weVec), 32'(we));
        check({tag, ".maddr"}, 32'(MAddr_MUX), 32'(maddr));
        check({tag, ".done"}, 32'(instr_done), 32'(done));
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "1"}, WE_NONE, 2'd0, 1'b0);
        cyc({tag, "2"}, WE_FETCH, 2'd0, 1'b0);
        check({tag, "2.xmux"}, 32'(X_MUX), 32'd1);
        check({tag, "2.ymux"}, 32'(Y_MUX), 32'd2);
        check({tag, "2.bmux"}, 32'(B_MUX), 32'd0);
        cyc({tag, "3"}, WE_Z, 2'd0, 1'b0);
        check({tag, "3.zmux"}, 32'(Z_MUX), 32'd1);
        check({tag, "3.alu"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        opcode = 3'd0;
        step();
        check("reset.all", 32'(allOut), 32'd0);
        rst = 1'b0;
        run = 1'b1;
        opcode = 3'd3;
        fetch("ca");
        cyc("ca4", WE_NONE, 2'd1, 1'b0);
        cyc("ca5", WE_A, 2'd0, 1'b1);
        check("ca5.amux", 32'(A_MUX), 32'd0);
        opcode = 3'd0;
        fetch("tc");
        cyc("tc4", WE_QZ, 2'd0, 1'b1);
        check("tc4.qmux", 32'(Q_MUX), 32'd2);
        check("tc4.zmux", 32'(Z_MUX), 32'd2);
        opcode = 3'd6;
        fetch("ad");
        cyc("ad4", WE_NONE, 2'd1, 1'b0);
        opcode = 3'd7;
        cyc("ad5", WE_YX, 2'd0, 1'b0);
        check("ad5.xmux", 32'(X_MUX), 32'd3);
        check("ad5.ymux", 32'(Y_MUX), 32'd0);
        cyc("ad6", WE_A, 2'd0, 1'b1);
        check("ad6.alu", 32'(alu_op), 32'd0);
        check("ad6.amux", 32'(A_MUX), 32'd1);
        fetch("mask");
        cyc("mask10", WE_NONE, 2'd1, 1'b0);
        opcode = 3'd5;
        cyc("mask11", WE_YX, 2'd0, 1'b0);
        cyc("mask12", WE_A, 2'd0, 1'b1);
        check("mask12.alu", 32'(alu_op), 32'd4);
        check("mask12.amux", 32'(A_MUX), 32'd1);
        fetch("ts");
        cyc("ts4", WE_MEM, 2'd1, 1'b1);
        opcode = 3'd4;
        fetch("cs");
        cyc("cs4", WE_NONE, 2'd1, 1'b0);
        cyc("cs5", WE_A, 2'd0, 1'b0);
        run = 1'b0;
        cyc("cs6", WE_A, 2'd0, 1'b1);
        check("cs6.amux", 32'(A_MUX), 32'd2);
        step();
        check("idle1.all", 32'(allOut), 32'd0);
        step();
        check("idle2.all", 32'(allOut), 32'd0);
        run = 1'b1;
        opcode = 3'd1;
        fetch("nop1_");
        cyc("nop1_4", WE_NONE, 2'd0, 1'b1);
        opcode = 3'd2;
        fetch("nop2_");
        cyc("nop2_4", WE_NONE, 2'd0, 1'b1);
        opcode = 3'd6;
        fetch("rst");
        cyc("rst4", WE_NONE, 2'd1, 1'b0);
        cyc("rst5", WE_YX, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid.all", 32'(allOut), 32'd0);
        @(negedge clk);
        check("rsthold.all", 32'(allOut), 32'd0);
        rst = 1'b0;
        cyc("post", WE_NONE, 2'd0, 1'b0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
